// File: rtl/riscv_pkg.sv
// Shared types for the multicycle RISC-V controller: opcodes, FSM states, mux encodings.
// MC_ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12
`ifdef MC_ILLEGAL_TRAP_EN
        , S_TRAP   = 4'd13
`endif
    } state_e;

    localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO   = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;

    typedef struct packed {
        logic             mem_req;
        logic             adr_src;
        logic             ir_write;
        logic             pc_write;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] result_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the current FSM state.
// MC_ILLEGAL_TRAP_EN: TRAP falls into the all-zero default.
module mc_ctrl_decode
    import riscv_pkg::*;
(
    input  state_e                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = branch_taken;
            end
            S_JALR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_UPPER: begin
                // LUI adds the immediate to zero; AUIPC adds it to the old PC
                ctrl.alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: state register, next-state logic, retire counter.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_o); otherwise they retire as NOPs.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                branch_taken_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                AdrSrc_o,
    output logic                IRWrite_o,
    output logic                PCWrite_o,
    output logic                MemWrite_o,
    output logic                RegWrite_o,
    output logic [SEL_W-1:0]    ALUSrcA_o,
    output logic [SEL_W-1:0]    ALUSrcB_o,
    output logic [SEL_W-1:0]    ALUOp_o,
    output logic [SEL_W-1:0]    ResultSrc_o,
    output logic                retired_o,
    output logic [RETIRE_W-1:0] retire_cnt_o,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic                illegal_o,
`endif
    output logic [STATE_W-1:0]  state_o
);

    state_e              state_q;
    state_e              state_d;
    ctrl_t               ctrl;
    logic [RETIRE_W-1:0] retire_cnt_q;
    logic                retire_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_UPPER:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH
    assign retire_c = !rst && (state_q != S_FETCH) && (state_d == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire_c) begin
            retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_o <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_o <= 1'b1;
        end
    end
`endif

    mc_ctrl_decode u_decode (
        .state        (state_q),
        .opcode       (opcode_i),
        .mem_ready    (mem_ready_i),
        .branch_taken (branch_taken_i),
        .ctrl         (ctrl)
    );

    // Side-effecting strobes are held low for the whole reset cycle
    assign mem_req_o    = ctrl.mem_req   && !rst;
    assign IRWrite_o    = ctrl.ir_write  && !rst;
    assign PCWrite_o    = ctrl.pc_write  && !rst;
    assign MemWrite_o   = ctrl.mem_write && !rst;
    assign RegWrite_o   = ctrl.reg_write && !rst;
    assign AdrSrc_o     = ctrl.adr_src;
    assign ALUSrcA_o    = ctrl.alu_src_a;
    assign ALUSrcB_o    = ctrl.alu_src_b;
    assign ALUOp_o      = ctrl.alu_op;
    assign ResultSrc_o  = ctrl.result_src;
    assign retired_o    = retire_c;
    assign retire_cnt_o = retire_cnt_q;
    assign state_o      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state paths built from instruction class,
// outputs checked every cycle. Honours MC_ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

    localparam int unsigned RW = 4;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11;
    localparam int UPPER = 12, TRAP = 13;

    localparam logic [6:0] O_LD = 7'b0000011, O_ST = 7'b0100011, O_R = 7'b0110011;
    localparam logic [6:0] O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_ILL = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode_i;
    logic          branch_taken_i;
    logic          mem_ready_i;
    logic          mem_req_o, AdrSrc_o, IRWrite_o, PCWrite_o, MemWrite_o, RegWrite_o;
    logic [1:0]    ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o;
    logic          retired_o;
    logic [RW-1:0] retire_cnt_o;
    logic [3:0]    state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic          illegal_o;
`endif

    multicycle_controller #(.RETIRE_W(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode_i       (opcode_i),
        .branch_taken_i (branch_taken_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .AdrSrc_o       (AdrSrc_o),
        .IRWrite_o      (IRWrite_o),
        .PCWrite_o      (PCWrite_o),
        .MemWrite_o     (MemWrite_o),
        .RegWrite_o     (RegWrite_o),
        .ALUSrcA_o      (ALUSrcA_o),
        .ALUSrcB_o      (ALUSrcB_o),
        .ALUOp_o        (ALUOp_o),
        .ResultSrc_o    (ResultSrc_o),
        .retired_o      (retired_o),
        .retire_cnt_o   (retire_cnt_o),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_o      (illegal_o),
`endif
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        logic       mr;
        logic       bt;
        logic [6:0] op;
        bit         last;
    } step_t;

    step_t         q[$];
    int            tests = 0;
    int            fails = 0;
    logic [RW-1:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, A, B, op, Result}
    function automatic logic [13:0] exp_ctrl(int st, logic mr, logic bt, logic [6:0] op);
        logic       mq, ad, irw, pcw, mw, rw;
        logic [1:0] a, b, o, r;
        {mq, ad, irw, pcw, mw, rw} = 6'b0;
        {a, b, o, r} = 8'b0;
        case (st)
            FETCH:    begin mq = 1; b = 2'b10; r = 2'b10; irw = mr; pcw = mr; end
            DECODE:   begin a = 2'b01; b = 2'b01; end
            MEMADR:   begin a = 2'b10; b = 2'b01; end
            MEMREAD:  begin mq = 1; ad = 1; end
            MEMWB:    begin r = 2'b01; rw = 1; end
            MEMWRITE: begin mq = 1; ad = 1; mw = 1; end
            EXECR:    begin a = 2'b10; o = 2'b10; end
            EXECI:    begin a = 2'b10; b = 2'b01; o = 2'b10; end
            ALUWB:    begin rw = 1; end
            BRANCH:   begin a = 2'b10; o = 2'b01; pcw = bt; end
            JALR:     begin a = 2'b10; b = 2'b01; end
            JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            UPPER:    begin a = (op == O_LUI) ? 2'b11 : 2'b01; b = 2'b01; end
            default:  ;
        endcase
        return {mq, ad, irw, pcw, mw, rw, a, b, o, r};
    endfunction

    task automatic add(input int st, input logic mr, input logic bt, input logic [6:0] op,
                       input bit last);
        step_t s;
        s.st = st; s.mr = mr; s.bt = bt; s.op = op; s.last = last;
        q.push_back(s);
    endtask

    task automatic add_dc(input int st, input logic [6:0] op, input bit last);
        add(st, 1'($urandom), 1'($urandom), op, last);
    endtask

    // Expected state path of one instruction, derived from its class
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic bt);
        for (int i = 0; i < fw; i++) add(FETCH, 1'b0, 1'($urandom), 7'($urandom), 1'b0);
        add(FETCH, 1'b1, 1'($urandom), 7'($urandom), 1'b0);
        add_dc(DECODE, op, 1'b0);
        case (op)
            O_LD: begin
                add_dc(MEMADR, op, 1'b0);
                for (int i = 0; i < mw; i++) add(MEMREAD, 1'b0, 1'($urandom), op, 1'b0);
                add(MEMREAD, 1'b1, 1'($urandom), op, 1'b0);
                add_dc(MEMWB, op, 1'b1);
            end
            O_ST: begin
                add_dc(MEMADR, op, 1'b0);
                for (int i = 0; i < mw; i++) add(MEMWRITE, 1'b0, 1'($urandom), op, 1'b0);
                add(MEMWRITE, 1'b1, 1'($urandom), op, 1'b1);
            end
            O_R:            begin add_dc(EXECR, op, 1'b0); add_dc(ALUWB, op, 1'b1); end
            O_I:            begin add_dc(EXECI, op, 1'b0); add_dc(ALUWB, op, 1'b1); end
            O_BR:           add(BRANCH, 1'($urandom), bt, op, 1'b1);
            O_JAL:          begin add_dc(JAL, op, 1'b0); add_dc(ALUWB, op, 1'b1); end
            O_JALR: begin
                add_dc(JALR, op, 1'b0); add_dc(JAL, op, 1'b0); add_dc(ALUWB, op, 1'b1);
            end
            O_LUI, O_AUIPC: begin add_dc(UPPER, op, 1'b0); add_dc(ALUWB, op, 1'b1); end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 12; i++) add_dc(TRAP, op, 1'b0);
`else
                q[q.size()-1].last = 1'b1;
`endif
            end
        endcase
    endtask

    task automatic do_step(input step_t s);
        mem_ready_i = s.mr; branch_taken_i = s.bt; opcode_i = s.op;
        @(negedge clk);
        chk("state", 32'(state_o), 32'(s.st));
        chk($sformatf("ctrl_st%0d", s.st),
            {MemWrite_o & 1'b0, mem_req_o, AdrSrc_o, IRWrite_o, PCWrite_o, MemWrite_o,
             RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o},
            32'(exp_ctrl(s.st, s.mr, s.bt, s.op)));
        chk("retired", 32'(retired_o), 32'(s.last));
        chk("retire_cnt", 32'(retire_cnt_o), 32'(exp_cnt));
`ifdef MC_ILLEGAL_TRAP_EN
        chk("illegal", 32'(illegal_o), 32'(s.st == TRAP));
`endif
        @(posedge clk); #1;
        if (s.last) exp_cnt = exp_cnt + RW'(1);
    endtask

    task automatic run_all();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            do_step(s);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            mem_ready_i = 1'b1; branch_taken_i = 1'b1; opcode_i = 7'($urandom);
            @(negedge clk);
            chk("rst_strobes", 32'({mem_req_o, IRWrite_o, PCWrite_o, MemWrite_o,
                                    RegWrite_o, retired_o}), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    logic [6:0] ops [10];
    step_t      s0;

    initial begin
        ops = '{O_LD, O_ST, O_R, O_I, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC, O_ILL};
        rst = 1'b1; mem_ready_i = 1'b0; branch_taken_i = 1'b0; opcode_i = '0;
        @(posedge clk); #1;
        do_reset(2);

        build(O_R, 0, 0, 1'b0);    run_all();
        build(O_LD, 1, 3, 1'b0);   run_all();
        build(O_BR, 0, 0, 1'b1);   run_all();
        build(O_BR, 0, 0, 1'b0);   run_all();
        build(O_JALR, 0, 0, 1'b0); run_all();
        build(O_LUI, 0, 0, 1'b0);  run_all();
        build(O_AUIPC, 2, 0, 1'b0); run_all();

        // Random mix; the 4-bit counter wraps several times along the way
        for (int n = 0; n < 40; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            build(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom));
`else
            build(ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom));
`endif
            run_all();
        end

        // Reset arriving in MEMWRITE
        if (exp_cnt == '0) begin build(O_R, 0, 0, 1'b0); run_all(); end
        build(O_ST, 0, 2, 1'b0);
        while (q[0].st != MEMWRITE) begin
            s0 = q.pop_front();
            do_step(s0);
        end
        q.delete();
        rst = 1'b1; mem_ready_i = 1'b1; branch_taken_i = 1'b0;
        @(negedge clk);
        chk("rst_mw_state", 32'(state_o), 32'(MEMWRITE));
        chk("rst_mw_strobes", 32'({MemWrite_o, mem_req_o, retired_o}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_cnt = '0;
        build(O_R, 0, 0, 1'b0); run_all();

        build(O_ILL, 0, 0, 1'b0); run_all();
`ifdef MC_ILLEGAL_TRAP_EN
        do_reset(1);
`endif
        build(O_I, 1, 0, 1'b0); run_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
